// File: rtl/ddr_mode_framer.sv
// ddr_mode_framer: HDR-DDR transmit framer. Fetches a descriptor and
// write payload from the register file and emits framed 20-bit words.
// Ports:
//   i_sys_clk, i_sys_rst_n      clock, async active-low reset
//   i_ddrmode_en, i_regf_base   level enable, descriptor pointer
//   o_regf_rd_en/addr, i_regf_data  register-file read port (1-cycle latency)
//   o_word/_bits/_valid, i_word_ready  framed word stream to serializer
//   o_rd_start, i_rd_done       read-path handoff
//   o_ddr_mode_done             one-cycle completion pulse
module ddr_mode_framer (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_ddrmode_en,
  input  logic [7:0]  i_regf_base,
  output logic        o_regf_rd_en,
  output logic [7:0]  o_regf_addr,
  input  logic [7:0]  i_regf_data,
  output logic [19:0] o_word,
  output logic [4:0]  o_word_bits,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_rd_start,
  input  logic        i_rd_done,
  output logic        o_ddr_mode_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DESC, S_CMD, S_FETCH,
    S_DATA, S_CRC, S_RD_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  tgt_q, tgt_d;
  logic [6:0]  cmd_q, cmd_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  hi_q, hi_d;
  logic [4:0]  crc_q, crc_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  addr_q, addr_d;
  logic [19:0] word_q, word_d;
  logic [4:0]  bits_q, bits_d;
  logic        valid_q, valid_d;
  logic        rd_start_q, rd_start_d;
  logic        done_q, done_d;
  logic        accept;

  function automatic logic [19:0] frame(
    input logic [1:0]  pre,
    input logic [15:0] pay
  );
    logic p1, p0;
    p1 = ^(pay & 16'hAAAA);
    p0 = ~(^(pay & 16'h5555));
    return {pre, pay, p1, p0};
  endfunction

  // x^5+x^2+1, payload fed MSB first
  function automatic logic [4:0] crc16(
    input logic [4:0]  c_in,
    input logic [15:0] d
  );
    logic [4:0] c;
    logic       fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign accept = valid_q & i_word_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    ptr_d      = ptr_q;
    rnw_d      = rnw_q;
    tgt_d      = tgt_q;
    cmd_d      = cmd_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    crc_d      = crc_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    word_d     = word_q;
    bits_d     = bits_q;
    valid_d    = valid_q;
    rd_start_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_ddrmode_en) begin
          state_d = S_DESC;
          base_d  = i_regf_base;
          ptr_d   = i_regf_base + 8'd3;
          cnt_d   = 3'd0;
        end
      end
      // cnt 0..2 issue reads, cnt 2..4 capture the returning bytes
      S_DESC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q <= 3'd2) begin
          rd_en_d = 1'b1;
          addr_d  = base_q + {6'd0, cnt_q[1:0]};
        end
        if (cnt_q == 3'd2) begin
          rnw_d = i_regf_data[7];
          tgt_d = i_regf_data[6:0];
        end
        if (cnt_q == 3'd3) cmd_d = i_regf_data[6:0];
        if (cnt_q == 3'd4) begin
          rem_d   = i_regf_data;
          crc_d   = 5'b11111;
          word_d  = frame(2'b01, {rnw_q, cmd_q, tgt_q, 1'b0});
          bits_d  = 5'd20;
          valid_d = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (accept) begin
          valid_d = 1'b0;
          cnt_d   = 3'd0;
          if (rnw_q) begin
            rd_start_d = 1'b1;
            state_d    = S_RD_WAIT;
          end else if (rem_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q <= 3'd1) begin
          rd_en_d = 1'b1;
          addr_d  = ptr_q;
          ptr_d   = ptr_q + 8'd1;
        end
        if (cnt_q == 3'd2) hi_d = i_regf_data;
        if (cnt_q == 3'd3) begin
          word_d  = frame(2'b10, {hi_q, i_regf_data});
          bits_d  = 5'd20;
          valid_d = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          valid_d = 1'b0;
          crc_d   = crc16(crc_q, word_q[17:2]);
          rem_d   = rem_q - 8'd1;
          cnt_d   = 3'd0;
          state_d = (rem_q == 8'd1) ? S_CRC : S_FETCH;
        end
      end
      // first cycle builds the word from the settled CRC
      S_CRC: begin
        if (!valid_q) begin
          word_d  = {2'b01, 4'b1100, crc_q, 9'd0};
          bits_d  = 5'd11;
          valid_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end
      // a done coincident with the start pulse is stale
      S_RD_WAIT: begin
        if (i_rd_done && !rd_start_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_ddrmode_en && state_q != S_DONE) begin
      state_d    = S_IDLE;
      rd_en_d    = 1'b0;
      addr_d     = 8'd0;
      word_d     = 20'd0;
      bits_d     = 5'd0;
      valid_d    = 1'b0;
      rd_start_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      base_q     <= 8'd0;
      ptr_q      <= 8'd0;
      rnw_q      <= 1'b0;
      tgt_q      <= 7'd0;
      cmd_q      <= 7'd0;
      rem_q      <= 8'd0;
      hi_q       <= 8'd0;
      crc_q      <= 5'b11111;
      rd_en_q    <= 1'b0;
      addr_q     <= 8'd0;
      word_q     <= 20'd0;
      bits_q     <= 5'd0;
      valid_q    <= 1'b0;
      rd_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      ptr_q      <= ptr_d;
      rnw_q      <= rnw_d;
      tgt_q      <= tgt_d;
      cmd_q      <= cmd_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      crc_q      <= crc_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      bits_q     <= bits_d;
      valid_q    <= valid_d;
      rd_start_q <= rd_start_d;
      done_q     <= done_d;
    end
  end

  assign o_regf_rd_en    = rd_en_q;
  assign o_regf_addr     = addr_q;
  assign o_word          = word_q;
  assign o_word_bits     = bits_q;
  assign o_word_valid    = valid_q;
  assign o_rd_start      = rd_start_q;
  assign o_ddr_mode_done = done_q;

endmodule

// File: tb/tb_ddr_mode_framer.sv
// tb_ddr_mode_framer: directed and random transactions against a
// frame-level reference model of the DDR framer.
module tb_ddr_mode_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  base;
  logic        rd_en;
  logic [7:0]  raddr;
  logic [7:0]  rdata;
  logic [19:0] word;
  logic [4:0]  bits;
  logic        valid;
  logic        ready;
  logic        rd_start;
  logic        rd_done;
  logic        done;

  always #5 clk = ~clk;

  ddr_mode_framer dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_ddrmode_en    (en),
    .i_regf_base     (base),
    .o_regf_rd_en    (rd_en),
    .o_regf_addr     (raddr),
    .i_regf_data     (rdata),
    .o_word          (word),
    .o_word_bits     (bits),
    .o_word_valid    (valid),
    .i_word_ready    (ready),
    .o_rd_start      (rd_start),
    .i_rd_done       (rd_done),
    .o_ddr_mode_done (done)
  );

  logic [7:0]  mem [256];
  logic [19:0] acc_w[$];
  logic [4:0]  acc_b[$];
  logic [7:0]  rd_log[$];
  logic [19:0] exp_w[$];
  logic [4:0]  exp_b[$];
  logic [7:0]  exp_ra[$];
  int          rises[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          hold_err = 0;
  logic        pend = 1'b0;
  logic [19:0] pw = 20'd0;
  logic [4:0]  pb = 5'd0;
  logic        m_rnw;
  int          last_w0, last_r0, last_done_at, first_rd;

  // register file with one-cycle read latency, plus stream monitors
  always @(posedge clk) begin
    rdata <= rd_en ? mem[raddr] : 8'($urandom);
    if (rd_en) rd_log.push_back(raddr);
    if (rst_n && valid && ready) begin
      acc_w.push_back(word);
      acc_b.push_back(bits);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rd_start) start_cnt <= start_cnt + 1;
    if (rst_n && pend && (!valid || word !== pw || bits !== pb))
      hold_err <= hold_err + 1;
    pend <= rst_n && en && valid && !ready;
    pw   <= word;
    pb   <= bits;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] pre,
                                     input logic [15:0] pay);
    int odd, even;
    odd = 0;
    even = 0;
    for (int i = 0; i < 16; i++)
      if (pay[i]) begin
        if (i % 2 == 1) odd++;
        else even++;
      end
    return {pre, pay, (odd % 2 == 1), (even % 2 == 0)};
  endfunction

  task automatic model(input logic [7:0] b);
    logic [7:0]  a, p, len, d0, d1;
    logic [15:0] pay;
    logic [4:0]  c;
    logic        fb;
    logic        bq[$];
    exp_w.delete();
    exp_b.delete();
    exp_ra.delete();
    a = b;         d0  = mem[a]; exp_ra.push_back(a);
    a = b + 8'd1;  d1  = mem[a]; exp_ra.push_back(a);
    a = b + 8'd2;  len = mem[a]; exp_ra.push_back(a);
    m_rnw = d0[7];
    pay = {d0[7], d1[6:0], d0[6:0], 1'b0};
    exp_w.push_back(mk(2'b01, pay));
    exp_b.push_back(5'd20);
    if (!m_rnw && len != 8'd0) begin
      p = b + 8'd3;
      for (int i = 0; i < int'(len); i++) begin
        pay[15:8] = mem[p]; exp_ra.push_back(p); p = p + 8'd1;
        pay[7:0]  = mem[p]; exp_ra.push_back(p); p = p + 8'd1;
        exp_w.push_back(mk(2'b10, pay));
        exp_b.push_back(5'd20);
        for (int k = 15; k >= 0; k--) bq.push_back(pay[k]);
      end
      c = 5'h1F;
      foreach (bq[k]) begin
        fb = c[4] ^ bq[k];
        c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      exp_w.push_back({2'b01, 4'b1100, c, 9'd0});
      exp_b.push_back(5'd11);
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: 7-cycle stall per word
  task automatic run(input logic [7:0] b, input int mode,
                     input int budget);
    int   w0, r0, d0, s0, cyc, stall, rdc, done_at, rdd_at, nw, nr;
    logic prev_v;
    model(b);
    w0 = acc_w.size(); r0 = rd_log.size();
    d0 = done_cnt;     s0 = start_cnt;
    rises.delete();
    base = b; en = 1'b1; rd_done = 1'b0;
    ready = (mode == 0);
    cyc = 0; stall = 0; rdc = 0; done_at = -1; rdd_at = -1;
    first_rd = -1; prev_v = 1'b0;
    while (cyc < budget && done_at < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (valid && !prev_v) rises.push_back(cyc);
      prev_v = valid;
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (done) begin
        done_at = cyc;
        en = 1'b0;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          if (valid && stall < 7) begin
            ready = 1'b0;
            stall++;
          end else begin
            ready = valid;
            stall = 0;
          end
        end
      endcase
      if (rd_done) rd_done = 1'b0;
      if (rd_start) begin
        rdc = 1;
        rd_done = 1'b1;
      end else if (rdc > 0) begin
        rdc++;
        if (rdc == 11) begin
          rd_done = 1'b1;
          rdd_at = cyc;
        end
      end
    end
    en = 1'b0;
    rd_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_seen", done_at >= 0, 1);
    nw = acc_w.size() - w0;
    nr = rd_log.size() - r0;
    chk("word_count", nw, exp_w.size());
    for (int i = 0; i < exp_w.size() && i < nw; i++) begin
      chk("word", acc_w[w0 + i], exp_w[i]);
      chk("word_bits", acc_b[w0 + i], exp_b[i]);
    end
    chk("read_count", nr, exp_ra.size());
    for (int i = 0; i < exp_ra.size() && i < nr; i++)
      chk("read_addr", rd_log[r0 + i], exp_ra[i]);
    chk("done_pulses", done_cnt - d0, 1);
    chk("rd_start_pulses", start_cnt - s0, m_rnw ? 1 : 0);
    if (m_rnw) chk("rd_done_to_done", done_at, rdd_at + 2);
    last_w0 = w0;
    last_r0 = r0;
    last_done_at = done_at;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid && n < budget);
    chk(tag, valid, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_rd_start"}, rd_start, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [19:0] w;
    logic [7:0]  b, a;
    int          d0;
    rst_n = 1'b0; en = 1'b0; base = 8'd0;
    ready = 1'b0; rd_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_addr", raddr, 0);
    chk("reset_word", word, 0);
    chk("reset_bits", bits, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // command-only write
    mem[8'h0A] = 8'h08; mem[8'h0B] = 8'h20; mem[8'h0C] = 8'h00;
    run(8'h0A, 0, 100);
    chk("cmd_word_value", acc_w[last_w0], 20'h48042);
    chk("first_read_at", first_rd, 2);
    chk("cmd_valid_at", rises[0], 6);
    chk("cmd_done_at", last_done_at, 8);

    // one-word write
    mem[8'h20] = 8'h12; mem[8'h21] = 8'h34; mem[8'h22] = 8'h01;
    mem[8'h23] = 8'hA5; mem[8'h24] = 8'h5A;
    run(8'h20, 0, 100);
    chk("data_word_value", acc_w[last_w0 + 1], 20'hA9569);
    w = acc_w[last_w0 + 2];
    chk("crc_word_value", w[19:9], 11'b01110010111);
    chk("crc_word_low", w[8:0], 0);
    chk("data_valid_at", rises[1], 11);
    chk("crc_valid_at", rises[2], 13);
    chk("crc_done_at", last_done_at, 15);

    // backpressure on a 3-word write
    mem[8'h40] = 8'h15; mem[8'h42] = 8'h03;
    run(8'h40, 2, 300);

    // read transaction
    mem[8'h60] = 8'h80 | 8'($urandom); mem[8'h62] = 8'h05;
    run(8'h60, 0, 200);

    // abort during FETCH
    mem[8'h80] = 8'h05; mem[8'h82] = 8'h02;
    d0 = done_cnt;
    base = 8'h80; en = 1'b1; ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_fetch_reading", rd_en, 1);
    en = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("abort_fetch");
    repeat (4) @(posedge clk);
    #1;
    chk("abort_fetch_no_done", done_cnt - d0, 0);

    // abort with a pending word, then a fresh run of the same descriptor
    mem[8'hA0] = 8'h33; mem[8'hA2] = 8'h02;
    d0 = done_cnt;
    base = 8'hA0; en = 1'b1; ready = 1'b1;
    wait_valid("abort_pend_cmd", 20);
    wait_valid("abort_pend_data1", 20);
    @(posedge clk); #1;
    ready = 1'b0;
    wait_valid("abort_pend_data2", 20);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("abort_pend");
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pend_no_done", done_cnt - d0, 0);
    run(8'hA0, 0, 200);

    // async reset while a data word is pending
    mem[8'hC0] = 8'h11; mem[8'hC2] = 8'h02;
    base = 8'hC0; en = 1'b1; ready = 1'b1;
    wait_valid("reset_mid_cmd", 20);
    @(posedge clk); #1;
    ready = 1'b0;
    wait_valid("reset_mid_data", 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_word", word, 0);
    chk("async_reset_bits", bits, 0);
    chk("async_reset_addr", raddr, 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pointer wrap past 0xFF
    mem[8'hFD] = 8'h2A; mem[8'hFE] = 8'h51; mem[8'hFF] = 8'h01;
    run(8'hFD, 0, 100);
    chk("wrap_addr_lo", rd_log[last_r0 + 3], 8'h00);
    chk("wrap_addr_hi", rd_log[last_r0 + 4], 8'h01);

    // random descriptors with random ready
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      mem[b] = {1'($urandom_range(0, 3) == 0), 7'($urandom)};
      a = b + 8'd2;
      mem[a] = 8'($urandom_range(0, 4));
      run(b, 1, 600);
    end

    chk("hold_violations", hold_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
